// File: rtl/angle_avg_pkg.sv
// Shared Q16.16 fixed-point definitions and sign-magnitude <-> two's complement helpers
// for the angle pipeline (arcsin stage, averager, qadd/qmulti family).
package angle_avg_pkg;

  localparam int          Q_FRAC  = 16;
  localparam logic [31:0] Q_ONE   = 32'h0001_0000;
  localparam logic [31:0] Q_DEG90 = 32'h005A_0000;
  localparam int          Q_SIGN  = 31;
  localparam int          TC_W    = 33;

  typedef enum logic {
    ST_FILL,
    ST_RUN
  } state_t;

  // Negative zero maps to plain zero because -0 == 0 in two's complement.
  function automatic logic signed [TC_W-1:0] sm_to_tc(input logic [31:0] v);
    logic signed [TC_W-1:0] mag;
    mag = {2'b00, v[Q_SIGN-1:0]};
    return v[Q_SIGN] ? -mag : mag;
  endfunction

  // Only strictly negative inputs set the sign bit, so zero never comes out as 0x8000_0000.
  function automatic logic [31:0] tc_to_sm(input logic signed [TC_W-1:0] v);
    logic signed [TC_W-1:0] mag;
    mag = v[TC_W-1] ? -v : v;
    return {v[TC_W-1], mag[Q_SIGN-1:0]};
  endfunction

endpackage

// File: rtl/angle_avg_ring.sv
// Circular window buffer: presents the entry at wr_ptr (the oldest sample once full)
// before that slot is overwritten by the incoming sample.
module angle_avg_ring
  import angle_avg_pkg::*;
#(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   wr_en,
  input  logic signed [TC_W-1:0] wr_data,
  output logic signed [TC_W-1:0] old
);

  localparam int N = 1 << DEPTH_LOG2;

  logic signed [TC_W-1:0] mem [N];
  logic [DEPTH_LOG2-1:0]  wr_ptr;

  // Pointer width equals log2(N), so the increment wraps mod N for free.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; stale entries are never read while count < N.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  assign old = mem[wr_ptr];

endmodule

// File: rtl/angle_avg.sv
// Sliding-window mean of the last 2^DEPTH_LOG2 Q16.16 angles, captured on rising edges
// of the producer's level valid; result is emitted one cycle after each full-window capture.
module angle_avg
  import angle_avg_pkg::*;
#(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_xita,
  input  logic        flush,
  output logic        out_valid,
  output logic [31:0] out_xita,
  output logic        out_full
);

  localparam int                SUM_W    = TC_W + DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  state_t                  state;
  logic                    in_valid_prev;
  logic                    cap;
  logic                    wr_en;
  logic                    pending;
  logic [DEPTH_LOG2:0]     count;
  logic [DEPTH_LOG2:0]     count_next;
  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] sum_next;
  logic signed [SUM_W-1:0] sum_shr;
  logic signed [TC_W-1:0]  sample;
  logic signed [TC_W-1:0]  ring_old;
  logic signed [TC_W-1:0]  old;
  logic signed [TC_W-1:0]  avg;

  assign wr_en = cap & ~flush & ~rst;

  angle_avg_ring #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ring (
    .clk    (clk),
    .rst    (rst),
    .clear  (flush),
    .wr_en  (wr_en),
    .wr_data(sample),
    .old    (ring_old)
  );

  always_comb begin
    state      = (count == FULL_CNT) ? ST_RUN : ST_FILL;
    cap        = in_valid & ~in_valid_prev;
    sample     = sm_to_tc(in_xita);
    // During FILL the slot under wr_ptr holds nothing that belongs to the window.
    old        = (state == ST_RUN) ? ring_old : '0;
    sum_next   = sum + SUM_W'(sample) - SUM_W'(old);
    count_next = (state == ST_RUN) ? count : count + 1'b1;
    sum_shr    = sum >>> DEPTH_LOG2;
    avg        = sum_shr[TC_W-1:0];
  end

  // NOTE: every register here uses non-blocking assignment so all state advances on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_valid_prev <= 1'b0;
      count         <= '0;
      sum           <= '0;
      pending       <= 1'b0;
      out_valid     <= 1'b0;
      out_xita      <= '0;
      out_full      <= 1'b0;
    end else begin
      in_valid_prev <= in_valid;
      if (flush) begin
        count     <= '0;
        sum       <= '0;
        pending   <= 1'b0;
        out_valid <= 1'b0;
        out_full  <= 1'b0;
      end else begin
        out_full  <= (state == ST_RUN);
        out_valid <= pending;
        if (pending) begin
          out_xita <= tc_to_sm(avg);
        end
        pending <= cap && (count_next == FULL_CNT);
        if (cap) begin
          sum   <= sum_next;
          count <= count_next;
        end
      end
    end
  end

endmodule
